// File: rtl/mem_wishbone_burst_bridge_if.sv
// mem_wishbone_burst_bridge_if: core mem_interface request/response plus Wishbone B4 master signals
interface mem_wishbone_burst_bridge_if #(parameter int ID_W = 2);
    logic            request;
    logic [29:0]     addr;
    logic [4:0]      rlen;
    logic            rnw;
    logic            rmw;
    logic [3:0]      wbe;
    logic [31:0]     wdata;
    logic [ID_W-1:0] id;
    logic            ack;
    logic            rvalid;
    logic [31:0]     rdata;
    logic [ID_W-1:0] rid;
    logic            write_outstanding;
    logic            inv;
    logic [29:0]     inv_addr;
    logic [29:0]     wb_adr;
    logic [31:0]     wb_dat_w;
    logic [3:0]      wb_sel;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [2:0]      wb_cti;
    logic [1:0]      wb_bte;
    logic [31:0]     wb_dat_r;
    logic            wb_ack;
    logic            wb_err;
    logic            bus_error;
    modport slave (
        input  request, addr, rlen, rnw, rmw, wbe, wdata, id, wb_dat_r, wb_ack, wb_err,
        output ack, rvalid, rdata, rid, write_outstanding, inv, inv_addr,
               wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, bus_error
    );
    modport master (
        output request, addr, rlen, rnw, rmw, wbe, wdata, id, wb_dat_r, wb_ack, wb_err,
        input  ack, rvalid, rdata, rid, write_outstanding, inv, inv_addr,
               wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, bus_error
    );
endinterface

// File: rtl/mem_wishbone_burst_bridge.sv
// mem_wishbone_burst_bridge: queued mem requests to Wishbone B4 bursts, single writes and locked RMW
module mem_wishbone_burst_bridge #(
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit BURST_EN   = 1'b1
) (
    input logic clk,
    input logic rst,
    mem_wishbone_burst_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(FIFO_DEPTH + 2) + 1;
    typedef struct packed {
        logic [29:0]     addr;
        logic [4:0]      rlen;
        logic            rnw;
        logic            rmw;
        logic [3:0]      wbe;
        logic [31:0]     wdata;
        logic [ID_W-1:0] id;
    } req_t;
    typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_GAP, RMW_WR} state_t;
    req_t            fifo_q [FIFO_DEPTH];
    req_t            head;
    state_t          state_q;
    logic [PW-1:0]   wptr_q, rptr_q, wptr_d, rptr_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            full, empty, push, pop, beat, wdone;
    logic [4:0]      cnt_q;
    logic [ID_W-1:0] id_q, rid_q;
    logic [3:0]      wbe_q, sel_q;
    logic [29:0]     adr_q;
    logic [31:0]     dat_w_q, rdata_q;
    logic [2:0]      cti_q;
    logic            cyc_q, stb_q, we_q, rvalid_q, berr_q;
    assign head   = fifo_q[rptr_q[AW-1:0]];
    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q - rptr_q) == PW'(FIFO_DEPTH);
    assign push   = bus.request & ~full;
    assign pop    = (state_q == IDLE) & ~empty;
    assign beat   = stb_q & (bus.wb_ack | bus.wb_err);
    assign wdone  = beat & ((state_q == WRITE) | (state_q == RMW_WR));
    assign wptr_d = wptr_q + PW'(push);
    assign rptr_d = rptr_q + PW'(pop);
    // Pending writes cover both queued entries and the one on the bus
    assign wcnt_d = wcnt_q + WW'(push & ~bus.rnw) - WW'(wdone);
    assign bus.ack               = push;
    assign bus.write_outstanding = wcnt_q != '0;
    assign bus.inv               = 1'b0;
    assign bus.inv_addr          = '0;
    assign bus.wb_adr            = adr_q;
    assign bus.wb_dat_w          = dat_w_q;
    assign bus.wb_sel            = sel_q;
    assign bus.wb_cyc            = cyc_q;
    assign bus.wb_stb            = stb_q;
    assign bus.wb_we             = we_q;
    assign bus.wb_cti            = cti_q;
    assign bus.wb_bte            = 2'b00;
    assign bus.rvalid            = rvalid_q;
    assign bus.rdata             = rdata_q;
    assign bus.rid               = rid_q;
    assign bus.bus_error         = berr_q;
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q[AW-1:0]] <= '{bus.addr, bus.rlen, bus.rnw, bus.rmw, bus.wbe, bus.wdata, bus.id};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            wcnt_q   <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            wbe_q    <= '0;
            adr_q    <= '0;
            dat_w_q  <= '0;
            sel_q    <= '0;
            cti_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            berr_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wcnt_q   <= wcnt_d;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            if (beat && (state_q == READ || state_q == RMW_RD)) begin
                rvalid_q <= 1'b1;
                rdata_q  <= bus.wb_err ? 32'h0 : bus.wb_dat_r;
                rid_q    <= id_q;
                berr_q   <= bus.wb_err;
            end
            case (state_q)
                IDLE: if (pop) begin
                    cnt_q   <= head.rlen;
                    adr_q   <= head.addr;
                    id_q    <= head.id;
                    wbe_q   <= head.wbe;
                    dat_w_q <= head.wdata;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= ~head.rnw & ~head.rmw;
                    sel_q   <= (~head.rnw & ~head.rmw) ? head.wbe : 4'hF;
                    cti_q   <= head.rnw ? (!BURST_EN ? 3'b000 : head.rlen != 5'd0 ? 3'b010 : 3'b111)
                                        : head.rmw ? 3'b000 : 3'b111;
                    state_q <= head.rnw ? READ : head.rmw ? RMW_RD : WRITE;
                end
                READ: if (beat) begin
                    adr_q   <= adr_q + 30'd1;
                    cnt_q   <= cnt_q - 5'd1;
                    cyc_q   <= BURST_EN && cnt_q != 5'd0;
                    stb_q   <= BURST_EN && cnt_q != 5'd0;
                    cti_q   <= BURST_EN ? (cnt_q == 5'd1 ? 3'b111 : 3'b010) : 3'b000;
                    state_q <= cnt_q == 5'd0 ? IDLE : READ;
                end else if (!cyc_q) begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                end
                RMW_RD: if (beat) begin
                    stb_q   <= 1'b0;
                    state_q <= RMW_GAP;
                end
                // cyc stays high through the gap so the fabric keeps the lock
                RMW_GAP: begin
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    sel_q   <= wbe_q;
                    cti_q   <= 3'b111;
                    state_q <= RMW_WR;
                end
                WRITE, RMW_WR: if (beat) begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wishbone_burst_bridge.sv
// tb_mem_wishbone_burst_bridge: randomized scoreboard bench with a memory reference model and Wishbone slave
module tb_mem_wishbone_burst_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_wishbone_burst_bridge_if #(.ID_W(2)) bus();
    mem_wishbone_burst_bridge #(.ID_W(2), .FIFO_DEPTH(4), .BURST_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [29:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [2:0]  cti;
        bit          cont;
        bit          gap;
    } beat_t;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        bit          err;
    } resp_t;
    beat_t bus_q[$];
    resp_t resp_q[$];
    logic [31:0] model_mem[logic [29:0]];
    logic [31:0] slave_mem[logic [29:0]];
    int checks = 0, failures = 0;
    bit hold = 0, err_en = 0, one_en = 0;
    logic [29:0] one_adr = '0;
    int stall_fixed = 0, wait_c = 0, rand_stall = 0, beats_done = 0;
    bit exp_cont = 0, exp_gap = 0, e_sl;
    beat_t b_sl;
    resp_t r_mon;

    function automatic logic [31:0] init_val(logic [29:0] a);
        return {a, 2'b00} ^ 32'hA5C3_0F1E;
    endfunction
    function automatic logic [31:0] mrd(logic [29:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] srd(logic [29:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction
    function automatic bit is_err(logic [29:0] a);
        return (err_en && a[3:0] == 4'hB) || (one_en && a == one_adr);
    endfunction
    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected bus beats and responses derived from the request alone
    task automatic push_exp(logic [29:0] a, logic [4:0] l, bit rnw, bit rmw, logic [3:0] be, logic [31:0] wd, logic [1:0] idv);
        logic [29:0] ai;
        if (rnw) begin
            for (int i = 0; i <= int'(l); i++) begin
                ai = a + 30'(i);
                bus_q.push_back('{ai, 1'b0, 4'hF, 32'h0, (i == int'(l)) ? 3'b111 : 3'b010, i != int'(l), 1'b0});
                resp_q.push_back('{is_err(ai) ? 32'h0 : mrd(ai), idv, is_err(ai)});
            end
        end else begin
            if (rmw) begin
                bus_q.push_back('{a, 1'b0, 4'hF, 32'h0, 3'b000, 1'b1, 1'b1});
                resp_q.push_back('{is_err(a) ? 32'h0 : mrd(a), idv, is_err(a)});
            end
            bus_q.push_back('{a, 1'b1, be, wd, 3'b111, 1'b0, 1'b0});
            if (!is_err(a)) model_mem[a] = merge(mrd(a), wd, be);
        end
    endtask
    task automatic drive(logic [29:0] a, logic [4:0] l, bit rnw, bit rmw, logic [3:0] be, logic [31:0] wd, logic [1:0] idv);
        bus.addr = a; bus.rlen = l; bus.rnw = rnw; bus.rmw = rmw;
        bus.wbe = be; bus.wdata = wd; bus.id = idv; bus.request = 1'b1;
    endtask
    task automatic issue(logic [29:0] a, logic [4:0] l, bit rnw, bit rmw, logic [3:0] be, logic [31:0] wd, logic [1:0] idv);
        int t = 0;
        @(negedge clk);
        drive(a, l, rnw, rmw, be, wd, idv);
        #1;
        while (!bus.ack && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.ack) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else push_exp(a, l, rnw, rmw, be, wd, idv);
        @(posedge clk);
        #1;
        bus.request = 1'b0;
    endtask
    task automatic wait_idle();
        int t = 0;
        while ((bus_q.size() != 0 || resp_q.size() != 0 || bus.wb_cyc) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_bus_beats", 64'(bus_q.size()), 0);
        check("drain_responses", 64'(resp_q.size()), 0);
    endtask

    // Wishbone slave: acks combinationally after a stall, errors on selected addresses
    always @(negedge clk) begin
        if (rst) begin
            bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_r = '0;
            wait_c = 0; exp_cont = 0; exp_gap = 0;
        end else begin
            if (exp_cont) check("cyc_held_between_beats", 64'(bus.wb_cyc), 1);
            if (exp_gap) check("rmw_gap_stb_cyc", {62'd0, bus.wb_stb, bus.wb_cyc}, 64'd1);
            exp_cont = 0; exp_gap = 0;
            bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
            if (bus.wb_cyc && bus.wb_stb) begin
                if (!hold && wait_c >= (stall_fixed >= 0 ? stall_fixed : rand_stall)) begin
                    e_sl = is_err(bus.wb_adr);
                    bus.wb_err = e_sl; bus.wb_ack = !e_sl; bus.wb_dat_r = srd(bus.wb_adr);
                    if (bus.wb_we && !e_sl) slave_mem[bus.wb_adr] = merge(srd(bus.wb_adr), bus.wb_dat_w, bus.wb_sel);
                    if (bus_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_bus_beat adr=%0h required=none", bus.wb_adr);
                    end else begin
                        b_sl = bus_q.pop_front();
                        check("bus_adr", 64'(bus.wb_adr), 64'(b_sl.adr));
                        check("bus_we", 64'(bus.wb_we), 64'(b_sl.we));
                        check("bus_sel", 64'(bus.wb_sel), 64'(b_sl.sel));
                        check("bus_cti", 64'(bus.wb_cti), 64'(b_sl.cti));
                        check("bus_bte", 64'(bus.wb_bte), 0);
                        if (b_sl.we) check("bus_dat_w", 64'(bus.wb_dat_w), 64'(b_sl.dat));
                        if (b_sl.we) check("write_outstanding_on_beat", 64'(bus.write_outstanding), 1);
                        exp_cont = b_sl.cont; exp_gap = b_sl.gap;
                    end
                    wait_c = 0;
                    rand_stall = $urandom_range(0, 2);
                    beats_done++;
                end else wait_c++;
            end else wait_c = 0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (bus.rvalid) begin
            if (resp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rvalid rid=%0d rdata=%0h required=none", bus.rid, bus.rdata);
            end else begin
                r_mon = resp_q.pop_front();
                check("rdata", 64'(bus.rdata), 64'(r_mon.data));
                check("rid", 64'(bus.rid), 64'(r_mon.id));
                check("bus_error", 64'(bus.bus_error), 64'(r_mon.err));
            end
        end else if (bus.bus_error) begin
            checks++; failures++;
            $display("FAIL stray_bus_error actual=1 required=0");
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, b0, c0, k;
        bit r;
        logic [29:0] a;
        logic [4:0] l;
        bus.request = 1'b0; bus.addr = '0; bus.rlen = '0; bus.rnw = 1'b0; bus.rmw = 1'b0;
        bus.wbe = '0; bus.wdata = '0; bus.id = '0;
        repeat (3) @(negedge clk);
        check("rst_wb_ctl", {bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_cti, bus.wb_bte, bus.wb_sel}, 0);
        check("rst_wb_adr_dat", {bus.wb_adr, bus.wb_dat_w}, 0);
        check("rst_resp", {bus.rvalid, bus.rdata, bus.rid, bus.bus_error}, 0);
        check("rst_misc", {bus.ack, bus.write_outstanding, bus.inv, bus.inv_addr}, 0);
        rst = 1'b0;
        // Single write with latency and write_outstanding tracking
        @(negedge clk);
        check("wo_idle", 64'(bus.write_outstanding), 0);
        b0 = beats_done;
        issue(30'h100, 5'd0, 1'b0, 1'b0, 4'b0011, 32'hDEAD_BEEF, 2'd1);
        @(negedge clk);
        check("latency_n1_cyc", 64'(bus.wb_cyc), 0);
        check("wo_after_accept", 64'(bus.write_outstanding), 1);
        @(negedge clk);
        check("latency_n2_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 64'd3);
        #1;
        t = 0;
        while (beats_done == b0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        check("wo_after_ack", 64'(bus.write_outstanding), 0);
        wait_idle();
        // Read burst with wrap and 2-cycle stalls
        stall_fixed = 2;
        issue(30'h3FFF_FFFE, 5'd3, 1'b1, 1'b0, 4'h0, 32'h0, 2'd2);
        wait_idle();
        // Same burst with an error on the second beat
        one_en = 1; one_adr = 30'h3FFF_FFFF;
        issue(30'h3FFF_FFFE, 5'd3, 1'b1, 1'b0, 4'h0, 32'h0, 2'd2);
        wait_idle();
        one_en = 0;
        stall_fixed = 0;
        // Locked RMW then read back the merged word
        model_mem[30'h40] = 32'h1234_5678;
        slave_mem[30'h40] = 32'h1234_5678;
        issue(30'h40, 5'd0, 1'b0, 1'b1, 4'b0110, 32'hCAFE_F00D, 2'd3);
        issue(30'h40, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd0);
        wait_idle();
        check("rmw_merged_word", 64'(mrd(30'h40)), 64'h12FE_F078);
        // FIFO full: one active, four queued, sixth held off until a slot frees
        hold = 1;
        for (int i = 0; i < 5; i++) issue(30'h200 + 30'(i), 5'd0, 1'b1, 1'b0, 4'h0, 32'h0, 2'(i));
        @(negedge clk);
        drive(30'h205, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("full_ack_low", 64'(bus.ack), 0);
            @(negedge clk);
        end
        #1;
        hold = 0;
        c0 = -1; k = -1;
        for (int c = 0; c < 30 && k < 0; c++) begin
            @(negedge clk);
            #1;
            if (c0 < 0 && !bus.wb_cyc) begin
                c0 = c;
                check("full_ack_low_on_pop", 64'(bus.ack), 0);
            end
            if (bus.ack) k = c;
        end
        check("full_accept_after_pop", 64'(k), 64'(c0 + 1));
        if (k >= 0) push_exp(30'h205, 5'd0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd1);
        @(posedge clk);
        #1;
        bus.request = 1'b0;
        wait_idle();
        // Reset during the first beat of a burst
        hold = 1;
        issue(30'h300, 5'd3, 1'b1, 1'b0, 4'h0, 32'h0, 2'd1);
        t = 0;
        while (!(bus.wb_cyc && bus.wb_stb) && t < 20) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("reset_drops_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 0);
        bus_q.delete();
        resp_q.delete();
        hold = 0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(30'h300, 5'd3, 1'b1, 1'b0, 4'h0, 32'h0, 2'd2);
        wait_idle();
        // Randomized mix of reads, writes and RMWs with random stalls and errors
        err_en = 1;
        stall_fixed = -1;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            a = 30'h3FFF_FFF0 + 30'($urandom_range(0, 31));
            l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r = k < 5;
            issue(a, l, r, !r && k >= 8, 4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();
        err_en = 0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
